// File: rtl/apb_cmd_queue.sv
// -----------------------------------------------------------------------------
// apb_cmd_queue
//
// Command buffer and sequencer in front of the APB master. A producer pushes
// 64-bit commands into a small FIFO. The sequencer issues them one at a time
// as a single-cycle cmd/cmd_vld pulse and waits for the master's completion.
// It then hands a response back to the producer. Only one command is ever in
// flight, so responses come back in push order.
//
// Command layout: [63:60] reserved, [59:56] pstrb, [55:48] op (0 read,
// 1 write), [47:32] paddr, [31:0] pwdata. Any op above 1 is rejected with
// rsp_err and is never issued.
//
// Optional feature macro: APB_CMDQ_TIMEOUT_EN
//   Defined   : WAIT aborts after TIMEOUT cycles without mst_done. The response
//               then carries rsp_timeout=1, rsp_err=1 and rsp_data=0. If
//               mst_done arrives in the expiring cycle, mst_done wins.
//   Undefined : WAIT waits indefinitely and rsp_timeout is constant 0.
//
// Ports:
//   pclk, presetn      clock, asynchronous active-low reset
//   in_cmd/in_vld      producer command and its valid
//   in_rdy             FIFO not full (combinational from the registered count)
//   cmd/cmd_vld        command to the master, one-cycle issue pulse
//   mst_done           master completion pulse
//   mst_rdata          read data, qualified by mst_done
//   mst_slverr         slave error, qualified by mst_done
//   rsp_vld/rsp_rdy    response handshake to the producer
//   rsp_data           read data; 0 for writes and errors
//   rsp_err            slave error or illegal op
//   rsp_timeout        transfer aborted by timeout
//   level              FIFO occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module apb_cmd_queue #(
  parameter int CMD_WIDTH  = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                     pclk,
  input  logic                     presetn,
  input  logic [CMD_WIDTH-1:0]     in_cmd,
  input  logic                     in_vld,
  output logic                     in_rdy,
  output logic [CMD_WIDTH-1:0]     cmd,
  output logic                     cmd_vld,
  input  logic                     mst_done,
  input  logic [DATA_WIDTH-1:0]    mst_rdata,
  input  logic                     mst_slverr,
  output logic                     rsp_vld,
  input  logic                     rsp_rdy,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_err,
  output logic                     rsp_timeout,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_CNT = LW'(DEPTH);

  // Supported range: DEPTH a power of two >= 2, TIMEOUT >= 1. This block
  // elaborates nothing; it names the legal parameter space in one place.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_unsupported_params
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // FIFO storage and bookkeeping
  logic [CMD_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [LW-1:0]        count_q;
  logic                 push_s;
  logic                 pop_s;
  logic [CMD_WIDTH-1:0] head_s;
  logic [7:0]           head_op_s;

  // Sequencer state and registered outputs
  state_e                state_q, state_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic                  cmd_vld_q, cmd_vld_d;
  logic                  rsp_vld_q, rsp_vld_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_tmo_q, rsp_tmo_d;

`ifdef APB_CMDQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

  // in_rdy depends only on full, so a pop never makes room in the same cycle.
  assign in_rdy    = (count_q != FULL_CNT);
  assign level     = count_q;
  assign push_s    = in_vld & in_rdy;
  assign head_s    = mem_q[rd_ptr_q];
  assign head_op_s = head_s[55:48];

  // FIFO data array; storage needs no reset because count_q qualifies it.
  always_ff @(posedge pclk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_cmd;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + LW'(1'b1);
        2'b01:   count_q <= count_q - LW'(1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Next-state and registered-output logic of the sequencer.
  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    cmd_vld_d  = 1'b0;
    rsp_vld_d  = rsp_vld_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsp_tmo_d  = rsp_tmo_q;
    pop_s      = 1'b0;
`ifdef APB_CMDQ_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop_s = 1'b1;
          if (head_op_s <= 8'd1) begin
            // cmd only changes on a real issue so it keeps the last issued value.
            state_d   = S_ISSUE;
            cmd_d     = head_s;
            cmd_vld_d = 1'b1;
          end else begin
            state_d    = S_RESP;
            rsp_vld_d  = 1'b1;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_tmo_d  = 1'b0;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
`ifdef APB_CMDQ_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
      end
      S_WAIT: begin
        if (mst_done) begin
          state_d    = S_RESP;
          rsp_vld_d  = 1'b1;
          // Data is only meaningful for a read that completed without error.
          if ((cmd_q[55:48] == 8'd0) && !mst_slverr) begin
            rsp_data_d = mst_rdata;
          end else begin
            rsp_data_d = '0;
          end
          rsp_err_d  = mst_slverr;
          rsp_tmo_d  = 1'b0;
        end else begin
`ifdef APB_CMDQ_TIMEOUT_EN
          // Count reaches TIMEOUT-1 on the TIMEOUT-th cycle after WAIT entry.
          if (tmo_cnt_q == TMO_LAST) begin
            state_d    = S_RESP;
            rsp_vld_d  = 1'b1;
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            rsp_tmo_d  = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TW'(1'b1);
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
      S_RESP: begin
        if (rsp_rdy) begin
          state_d   = S_IDLE;
          rsp_vld_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d   = S_IDLE;
        rsp_vld_d = 1'b0;
      end
    endcase
  end

  // Sequencer state and output registers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      cmd_vld_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsp_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      cmd_vld_q  <= cmd_vld_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsp_tmo_q  <= rsp_tmo_d;
    end
  end

`ifdef APB_CMDQ_TIMEOUT_EN
  // Timeout counter for the WAIT state.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
  assign rsp_timeout = rsp_tmo_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign cmd      = cmd_q;
  assign cmd_vld  = cmd_vld_q;
  assign rsp_vld  = rsp_vld_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_apb_cmd_queue
//
// Directed self-checking bench for apb_cmd_queue. The bench drives inputs and
// samples outputs 1 ns after each rising edge. A single check task compares
// observed and expected values and counts both. The timeout scenario is only
// compiled when APB_CMDQ_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_apb_cmd_queue;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [63:0] in_cmd;
  logic        in_vld;
  logic        in_rdy;
  logic [63:0] cmd;
  logic        cmd_vld;
  logic        mst_done;
  logic [31:0] mst_rdata;
  logic        mst_slverr;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [2:0]  level;

  int n_checks = 0;
  int n_errors = 0;

  apb_cmd_queue #(
    .CMD_WIDTH(64), .DATA_WIDTH(32), .DEPTH(4), .TIMEOUT(16)
  ) dut (
    .pclk(pclk), .presetn(presetn),
    .in_cmd(in_cmd), .in_vld(in_vld), .in_rdy(in_rdy),
    .cmd(cmd), .cmd_vld(cmd_vld),
    .mst_done(mst_done), .mst_rdata(mst_rdata), .mst_slverr(mst_slverr),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .level(level)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_cmd(input logic [7:0] op, input logic [15:0] addr,
                                         input logic [31:0] wdata);
    return {4'h0, 4'hf, op, addr, wdata};
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input logic [63:0] c);
    in_cmd = c;
    in_vld = 1'b1;
    step();
    in_vld = 1'b0;
  endtask

  // Waits (bounded) for the issue pulse, checks the command and the pulse width.
  task automatic wait_issue(input string tag, input logic [63:0] exp_cmd, output int lat);
    lat = 0;
    while (!cmd_vld && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_issue_seen"}, {63'd0, cmd_vld}, 64'd1);
    check({tag, "_issue_cmd"}, cmd, exp_cmd);
    step();
    check({tag, "_issue_pulse_end"}, {63'd0, cmd_vld}, 64'd0);
  endtask

  task automatic complete(input logic [31:0] rdata, input logic slverr);
    mst_done   = 1'b1;
    mst_rdata  = rdata;
    mst_slverr = slverr;
    step();
    mst_done   = 1'b0;
    mst_rdata  = 32'h0;
    mst_slverr = 1'b0;
  endtask

  // Waits (bounded) for a response, checks it and accepts it.
  task automatic accept_rsp(input string tag, input logic [31:0] exp_data,
                            input logic exp_err, input logic exp_tmo);
    int n = 0;
    while (!rsp_vld && n < 40) begin
      step();
      n++;
    end
    check({tag, "_rsp_vld"}, {63'd0, rsp_vld}, 64'd1);
    check({tag, "_rsp_data"}, {32'd0, rsp_data}, {32'd0, exp_data});
    check({tag, "_rsp_err"}, {63'd0, rsp_err}, {63'd0, exp_err});
    check({tag, "_rsp_timeout"}, {63'd0, rsp_timeout}, {63'd0, exp_tmo});
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check({tag, "_rsp_dropped"}, {63'd0, rsp_vld}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd"}, cmd, 64'd0);
    check({tag, "_cmd_vld"}, {63'd0, cmd_vld}, 64'd0);
    check({tag, "_rsp_vld"}, {63'd0, rsp_vld}, 64'd0);
    check({tag, "_rsp_data"}, {32'd0, rsp_data}, 64'd0);
    check({tag, "_rsp_err"}, {63'd0, rsp_err}, 64'd0);
    check({tag, "_rsp_timeout"}, {63'd0, rsp_timeout}, 64'd0);
    check({tag, "_level"}, {61'd0, level}, 64'd0);
    check({tag, "_in_rdy"}, {63'd0, in_rdy}, 64'd1);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    presetn    = 1'b0;
    in_cmd     = 64'd0;
    in_vld     = 1'b0;
    mst_done   = 1'b0;
    mst_rdata  = 32'd0;
    mst_slverr = 1'b0;
    rsp_rdy    = 1'b0;

    // Reset state
    step();
    step();
    check_reset_outputs("reset");
    presetn = 1'b1;
    step();

    // Single read: issue one cycle after push, response carries rdata
    push(mk_cmd(8'h00, 16'h4000, 32'h0));
    check("rd_level_after_push", {61'd0, level}, 64'd1);
    check("rd_no_early_issue", {63'd0, cmd_vld}, 64'd0);
    wait_issue("rd", mk_cmd(8'h00, 16'h4000, 32'h0), lat);
    check("rd_issue_latency", lat, 64'd1);
    complete(32'hDEADBEEF, 1'b0);
    check("rd_rsp_same_edge", {63'd0, rsp_vld}, 64'd1);
    step();
    check("rd_rsp_held", {63'd0, rsp_vld}, 64'd1);
    check("rd_rsp_data_held", {32'd0, rsp_data}, 64'hDEADBEEF);
    accept_rsp("rd", 32'hDEADBEEF, 1'b0, 1'b0);

    // Write with slave error: data forced to 0
    push(mk_cmd(8'h01, 16'h4001, 32'h1));
    wait_issue("wr", mk_cmd(8'h01, 16'h4001, 32'h1), lat);
    complete(32'h12345678, 1'b1);
    accept_rsp("wr", 32'h0, 1'b1, 1'b0);

    // Five back-to-back pushes with the master stalled: one in flight, four queued
    for (int i = 0; i < 5; i++) begin
      in_cmd = mk_cmd(8'h00, 16'h4000 + 16'(i), 32'h0);
      in_vld = 1'b1;
      step();
    end
    in_vld = 1'b0;
    check("full_level", {61'd0, level}, 64'd4);
    check("full_in_rdy", {63'd0, in_rdy}, 64'd0);
    push(mk_cmd(8'h00, 16'h4005, 32'h0));
    check("full_no_push", {61'd0, level}, 64'd4);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) begin
        check("order0_cmd", cmd, mk_cmd(8'h00, 16'h4000, 32'h0));
      end else begin
        wait_issue("order", mk_cmd(8'h00, 16'h4000 + 16'(i), 32'h0), lat);
        check("b2b_issue_latency", lat, 64'd1);
      end
      complete(32'h1000 + 32'(i), 1'b0);
      accept_rsp("order", 32'h1000 + 32'(i), 1'b0, 1'b0);
    end

    // Illegal op is answered without issue; the next command issues normally
    push(mk_cmd(8'h02, 16'h5000, 32'h0));
    push(mk_cmd(8'h00, 16'h5001, 32'h0));
    check("ill_rsp_vld", {63'd0, rsp_vld}, 64'd1);
    check("ill_no_cmd_vld", {63'd0, cmd_vld}, 64'd0);
    check("ill_cmd_kept", cmd, mk_cmd(8'h00, 16'h4004, 32'h0));
    accept_rsp("ill", 32'h0, 1'b1, 1'b0);
    wait_issue("post_ill", mk_cmd(8'h00, 16'h5001, 32'h0), lat);
    check("post_ill_latency", lat, 64'd1);
    complete(32'hCAFEF00D, 1'b0);
    accept_rsp("post_ill", 32'hCAFEF00D, 1'b0, 1'b0);

`ifdef APB_CMDQ_TIMEOUT_EN
    // Master never answers: abort exactly 16 cycles after WAIT entry
    push(mk_cmd(8'h00, 16'h7000, 32'h0));
    wait_issue("tmo", mk_cmd(8'h00, 16'h7000, 32'h0), lat);
    for (int i = 0; i < 15; i++) begin
      step();
    end
    check("tmo_not_yet", {63'd0, rsp_vld}, 64'd0);
    step();
    check("tmo_rsp_vld", {63'd0, rsp_vld}, 64'd1);
    check("tmo_flag", {63'd0, rsp_timeout}, 64'd1);
    complete(32'hBAD0BAD0, 1'b0);
    accept_rsp("tmo", 32'h0, 1'b1, 1'b1);
`endif

    // Reset in WAIT with two entries queued flushes everything
    push(mk_cmd(8'h00, 16'h6000, 32'h0));
    push(mk_cmd(8'h00, 16'h6001, 32'h0));
    push(mk_cmd(8'h00, 16'h6002, 32'h0));
    check("rst_pre_level", {61'd0, level}, 64'd2);
    presetn = 1'b0;
    #1;
    check_reset_outputs("midrst");
    step();
    presetn = 1'b1;
    complete(32'h55555555, 1'b0);
    check("late_done_ignored", {63'd0, rsp_vld}, 64'd0);
    check("late_done_level", {61'd0, level}, 64'd0);
    push(mk_cmd(8'h01, 16'h6100, 32'hA5A5A5A5));
    wait_issue("post_rst", mk_cmd(8'h01, 16'h6100, 32'hA5A5A5A5), lat);
    check("post_rst_latency", lat, 64'd1);
    complete(32'h77777777, 1'b0);
    accept_rsp("post_rst", 32'h0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
